bus_dest_bank: RTL and testbench
================================

# bus_dest_bank

Destination end of the datapath bus: captures `busMuxOut` into the architectural registers the bus multiplexer reads from. Uses the same 5-bit source encoding as the bus select, so a select code names the same register on both ends. Provides a registered read port with write bypass, a PC auto-increment path and write-fault bookkeeping. Sits between the bus multiplexer output and the register inputs of the multiplexer.

## Interface
- `WIDTH`, 32, data width of bus and every register
- `PC_STEP`, 4, amount added to PC on `pcInc`
- `CNT_W`, 16, width of the saturating write counter
- `clock`  in  1  rising-edge clock
- `clear`  in  1  reset; one clock, synchronous, active-high
- `busMuxOut`  in  WIDTH  value currently driven on the bus
- `destSel`  in  5  destination code (same encoding as bus select)
- `writeEn`  in  1  commit `busMuxOut` to `destSel` at this edge
- `readSel`  in  5  read-port code
- `readData`  out  WIDTH  registered read result
- `pcInc`  in  1  advance PC by `PC_STEP`
- `pcOut`  out  WIDTH  current PC, direct from the register
- `mdrOut`  out  WIDTH  current MDR, direct from the register
- `illegalWr`  out  1  sticky: write attempted to a non-writable code
- `wrCount`  out  CNT_W  count of accepted writes, saturating

## Operation
- Code map: 0–15 = R0–R15, 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLO, 20 = PC, 21 = MDR, 22 = INPORT, 23 = C (sign-extend), 24–31 unused.
- Writable: 0–17, 20, 21. R0 is a real register, not hardwired to zero.
- Read-only codes: 18, 19, 22, 23. Unused codes: 24–31.
- A write with `writeEn` = 1 to a read-only or unused code is dropped. It sets `illegalWr` and does not increment `wrCount`.
- An accepted write updates exactly one register. It increments `wrCount`, which saturates at all-ones.
- `illegalWr` clears only on `clear`.
- PC update priority: a PC write (`writeEn` = 1, `destSel` = 20) beats `pcInc`. `pcInc` alone does PC ← PC + `PC_STEP` modulo 2^WIDTH, so all-ones wraps to PC_STEP−1.
- Read port: `readData` ← value of `readSel`, registered.
- Bypass: if `writeEn`, `destSel` = `readSel` and the code is writable, `readData` takes `busMuxOut`.
- PC bypass: if `readSel` = 20 and `pcInc` is applied with no PC write, `readData` takes the incremented PC.
- Reads of codes 18, 19, 22, 23 and 24–31 return 0, because this block does not own those registers.
- No state machine beyond the register state. Every input is sampled each edge.

## Timing
- All state changes happen on the rising `clock` edge.
- `clear` = 1 at an edge sets every register, `readData`, `wrCount` and `illegalWr` to 0.
- `clear` has priority over a simultaneous `writeEn` or `pcInc`; neither takes effect on that edge.
- Write latency: the target register shows the new value one edge after `writeEn` is sampled.
- `pcOut` and `mdrOut` change at that same edge.
- Read latency: 1 edge. `readData` at edge n+1 reflects `readSel` and the post-edge-n state, including bypass.
- Back-to-back writes to the same code on consecutive cycles: the last one wins. Each accepted write counts.
- `wrCount` increment and `illegalWr` set become visible at the same edge as the write.

## Test plan
- Reset: hold `clear` 1 for 1 edge with `writeEn` = 1, `destSel` = 3, `busMuxOut` = 0xDEADBEEF -> after the edge, all outputs are 0 and R3 reads 0 one cycle later.
- Write/read: write 230 to code 3, then `readSel` = 3 -> `readData` = 230 one edge later; `wrCount` = 1.
- Bypass: same edge `writeEn` = 1, `destSel` = `readSel` = 17, `busMuxOut` = 0x1234 -> `readData` = 0x1234 after that edge.
- PC: PC = 0xFFFFFFFE, `pcInc` -> `pcOut` = 0x00000002. Then `pcInc` + write 0x100 to code 20 on the same edge -> `pcOut` = 0x100.
- Illegal write: write 0x55 to code 18, then code 27 -> `illegalWr` = 1 after the first edge, `wrCount` unchanged, `readSel` = 18 gives 0; `illegalWr` stays 1 until `clear`.
- Saturation: with CNT_W = 4, perform 17 accepted writes -> `wrCount` = 15 and holds.

Source files
------------

// File: rtl/bus_dest_bank.sv
// bus_dest_bank: bus destination registers with bypassed read port, PC increment and write-fault tracking
module bus_dest_bank #(
    parameter int WIDTH   = 32,
    parameter int PC_STEP = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] busMuxOut,
    input  logic [4:0]       destSel,
    input  logic             writeEn,
    input  logic [4:0]       readSel,
    output logic [WIDTH-1:0] readData,
    input  logic             pcInc,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] mdrOut,
    output logic             illegalWr,
    output logic [CNT_W-1:0] wrCount
);
    logic [WIDTH-1:0] rf [0:17];
    logic             dest_ok;
    logic             accept;
    logic             byp;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] read_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    always_comb begin
        dest_ok  = destSel < 5'd18 || destSel == 5'd20 || destSel == 5'd21;
        accept   = writeEn && dest_ok;
        byp      = accept && destSel == readSel;
        pc_nxt   = (accept && destSel == 5'd20) ? busMuxOut
                 : pcInc ? pcOut + WIDTH'(PC_STEP) : pcOut;
        // readData shows post-edge state, so PC and bypassed writes come from next-state values
        read_nxt = readSel == 5'd20 ? pc_nxt
                 : byp ? busMuxOut
                 : readSel < 5'd18 ? rf[readSel]
                 : readSel == 5'd21 ? mdrOut : '0;
        cnt_nxt  = (accept && !(&wrCount)) ? wrCount + 1'b1 : wrCount;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 18; i++) rf[i] <= '0;
            pcOut     <= '0;
            mdrOut    <= '0;
            readData  <= '0;
            wrCount   <= '0;
            illegalWr <= 1'b0;
        end else begin
            if (accept && destSel < 5'd18) rf[destSel] <= busMuxOut;
            if (accept && destSel == 5'd21) mdrOut <= busMuxOut;
            pcOut     <= pc_nxt;
            readData  <= read_nxt;
            wrCount   <= cnt_nxt;
            illegalWr <= illegalWr || (writeEn && !dest_ok);
        end
    end
endmodule

// File: tb/tb_bus_dest_bank.sv
// tb_bus_dest_bank: directed and random checks of bus_dest_bank against a code-indexed register model
module tb_bus_dest_bank;
    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] bus = '0;
    logic [4:0]  dsel = '0;
    logic        we = 1'b0;
    logic [4:0]  rsel = '0;
    logic [31:0] rdata;
    logic        inc = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] mdr_o;
    logic        ill_o;
    logic [3:0]  cnt_o;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] m [32];
    int          cnt;
    bit          ill;
    logic [31:0] erd;

    bus_dest_bank #(.WIDTH(32), .PC_STEP(4), .CNT_W(4)) dut (
        .clock(clk), .clear(clear), .busMuxOut(bus), .destSel(dsel), .writeEn(we),
        .readSel(rsel), .readData(rdata), .pcInc(inc), .pcOut(pc_o), .mdrOut(mdr_o),
        .illegalWr(ill_o), .wrCount(cnt_o)
    );

    always #5 clk = ~clk;

    function automatic bit writable(input int c);
        return c <= 17 || c == 20 || c == 21;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit c, input bit w, input int d, input logic [31:0] b,
                        input int r, input bit i);
        @(negedge clk);
        clear = c; we = w; dsel = 5'(d); bus = b; rsel = 5'(r); inc = i;
        @(posedge clk);
        if (c) begin
            foreach (m[k]) m[k] = '0;
            cnt = 0; ill = 0;
        end else begin
            if (i && !(w && d == 20)) m[20] = m[20] + 32'd4;
            if (w) begin
                if (writable(d)) begin
                    m[d] = b;
                    cnt = cnt == 15 ? 15 : cnt + 1;
                end else ill = 1;
            end
        end
        erd = (writable(r) && !c) ? m[r] : 32'h0;
        #1;
        check("readData", rdata, erd);
        check("pcOut", pc_o, m[20]);
        check("mdrOut", mdr_o, m[21]);
        check("illegalWr", 32'(ill_o), 32'(ill));
        check("wrCount", 32'(cnt_o), 32'(cnt));
    endtask

    initial begin
        foreach (m[k]) m[k] = '0;
        cnt = 0; ill = 0;
        // reset beats a simultaneous write
        step(1, 1, 3, 32'hDEADBEEF, 3, 1);
        step(0, 0, 0, 0, 3, 0);
        // write then read
        step(0, 1, 3, 32'd230, 0, 0);
        step(0, 0, 0, 0, 3, 0);
        check("wrCount_after_one", 32'(cnt_o), 32'd1);
        check("R3_read", rdata, 32'd230);
        // bypass on LO
        step(0, 1, 17, 32'h1234, 17, 0);
        check("bypass_LO", rdata, 32'h1234);
        // PC wrap, PC read bypass, write-over-increment priority
        step(0, 1, 20, 32'hFFFFFFFE, 0, 0);
        step(0, 0, 0, 0, 20, 1);
        check("pc_wrap", pc_o, 32'h2);
        check("pc_read_bypass", rdata, 32'h2);
        step(0, 1, 20, 32'h100, 20, 1);
        check("pc_write_wins", pc_o, 32'h100);
        // MDR
        step(0, 1, 21, 32'hA5A5A5A5, 21, 0);
        check("mdr_write", mdr_o, 32'hA5A5A5A5);
        // illegal writes
        step(0, 1, 18, 32'h55, 18, 0);
        check("illegal_set", 32'(ill_o), 32'd1);
        step(0, 1, 27, 32'h55, 18, 0);
        check("illegal_read_zero", rdata, 32'h0);
        step(0, 0, 0, 0, 23, 0);
        check("illegal_sticky", 32'(ill_o), 32'd1);
        // saturation after 17 accepted writes from reset
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) step(0, 1, k % 16, 32'(k * 7 + 1), k % 16, 0);
        check("wrCount_saturated", 32'(cnt_o), 32'd15);
        step(0, 1, 0, 32'h9, 0, 0);
        check("wrCount_holds", 32'(cnt_o), 32'd15);
        // random traffic
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0 ? $urandom_range(16, 31) : $urandom_range(0, 21),
                 $urandom, $urandom_range(0, 31), $urandom_range(0, 3) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
